// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps a 4:1 single-bit mux through its channels, waits
// SETTLE_CYC cycles after each select change, samples the mux output and
// hands the assembled 4-bit snapshot downstream over valid/ready.
// Optional feature macro: SCAN_CHANGE_DET_EN (suppress unchanged snapshots).
module mux_scan_sampler #(
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       mux_op,
   output logic [1:0] sel_out,
   output logic [3:0] snap,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic       busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SNAP_W = 4;
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // With no settle time a channel goes straight to its sample cycle.
   localparam state_t FIRST_ST = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

   state_t             state_q;
   logic [1:0]         sel_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SNAP_W-1:0]  shift_q;
   logic [SNAP_W-1:0]  snap_q;
   logic               valid_q;
   logic               busy_q;
   logic [SNAP_W-1:0]  snap_new_c;

`ifdef SCAN_CHANGE_DET_EN
   logic               emitted_q;
`endif

   // Completed snapshot: the three stored bits plus the bit being sampled now.
   assign snap_new_c = {mux_op, shift_q[2:0]};

   // Scan sequencer: state, select, settle counter, capture and output regs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         cnt_q     <= '0;
         shift_q   <= '0;
         snap_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SCAN_CHANGE_DET_EN
         emitted_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               sel_q <= 2'd0;
               if (start) begin
                  state_q <= FIRST_ST;
                  cnt_q   <= SETTLE_LD;
                  busy_q  <= 1'b1;
               end
            end

            SETTLE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_q <= SAMPLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            SAMPLE: begin
               shift_q[sel_q] <= mux_op;
               if (sel_q != 2'd3) begin
                  sel_q   <= 2'(sel_q + 2'd1);
                  cnt_q   <= SETTLE_LD;
                  state_q <= FIRST_ST;
               end else begin
`ifdef SCAN_CHANGE_DET_EN
                  if (emitted_q && (snap_new_c == snap_q)) begin
                     // Unchanged: skip emission and act as if accepted.
                     sel_q <= 2'd0;
                     if (cont) begin
                        cnt_q   <= SETTLE_LD;
                        state_q <= FIRST_ST;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     snap_q    <= snap_new_c;
                     valid_q   <= 1'b1;
                     emitted_q <= 1'b1;
                     state_q   <= HOLD;
                  end
`else
                  snap_q  <= snap_new_c;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
`endif
               end
            end

            HOLD: begin
               if (valid_q && snap_ready) begin
                  valid_q <= 1'b0;
                  sel_q   <= 2'd0;
                  if (cont) begin
                     cnt_q   <= SETTLE_LD;
                     state_q <= FIRST_ST;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sel_out    = sel_q;
   assign snap       = snap_q;
   assign snap_valid = valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler with a behavioural 4:1 mux and a
// scoreboard of expected snapshots popped on each accepted handshake.
module tb_mux_scan_sampler;

   localparam int unsigned S        = 1;
   localparam int unsigned SCAN_LAT = 4 * (S + 1) + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       snap_ready = 1'b0;
   logic [3:0] chans = 4'b0000;
   logic       mux_op;
   logic [1:0] sel_out;
   logic [3:0] snap;
   logic       snap_valid;
   logic       busy;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   // Behavioural 4:1 mux driven by the DUT select.
   assign mux_op = chans[sel_out];

   mux_scan_sampler #(.SETTLE_CYC(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cont       (cont),
      .mux_op     (mux_op),
      .sel_out    (sel_out),
      .snap       (snap),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .busy       (busy)
   );

   // Scoreboard: every accepted snapshot must match the next expected value.
   always @(negedge clk) begin : sb_mon
      logic [3:0] e;
      if (!rst && snap_valid && snap_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected snap=%b", snap);
         end else begin
            e = exp_q.pop_front();
            if (snap !== e) begin
               errors++;
               $display("FAIL sb_snap got=%b exp=%b", snap, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; cont = 1'b0; snap_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, output int n);
      n = 0;
      while (!snap_valid && n < max_cyc) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({sel_out, snap, snap_valid, busy} !== 8'd0) begin
         errors++;
         $display("FAIL reset_vals got sel=%0d snap=%b v=%b busy=%b exp all 0",
                  sel_out, snap, snap_valid, busy);
      end
      chans = 4'b1010;
      repeat (20) begin
         checks++;
         if (sel_out !== 2'd0 || snap_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got sel=%0d v=%b busy=%b exp 0/0/0",
                     sel_out, snap_valid, busy);
         end
         step();
      end
   endtask

   task automatic test_single();
      logic [1:0] es;
      do_reset();
      chans = 4'b1010;
      snap_ready = 1'b1;
      exp_q.push_back(4'b1010);
      pulse_start();
      for (int c = 1; c <= 8; c++) begin
         es = 2'((c - 1) / (S + 1));
         checks++;
         if (sel_out !== es || snap_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_seq cyc=%0d got sel=%0d v=%b busy=%b exp sel=%0d v=0 busy=1",
                     c, sel_out, snap_valid, busy, es);
         end
         step();
      end
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b1010) begin
         errors++;
         $display("FAIL single_latency got v=%b snap=%b exp v=1 snap=1010", snap_valid, snap);
      end
      step();
      checks++;
      if (snap_valid !== 1'b0 || busy !== 1'b0 || sel_out !== 2'd0) begin
         errors++;
         $display("FAIL single_done got v=%b busy=%b sel=%0d exp 0/0/0", snap_valid, busy, sel_out);
      end
      snap_ready = 1'b0;
   endtask

   task automatic test_hold();
      int n;
      do_reset();
      chans = 4'b1010;
      snap_ready = 1'b0;
      exp_q.push_back(4'b1010);
      pulse_start();
      wait_valid(4 * SCAN_LAT, n);
      checks++;
      if (snap_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_timeout got v=%b exp 1", snap_valid);
      end
      chans = 4'b0101;
      repeat (5) begin
         checks++;
         if (snap_valid !== 1'b1 || snap !== 4'b1010) begin
            errors++;
            $display("FAIL hold_stable got v=%b snap=%b exp v=1 snap=1010", snap_valid, snap);
         end
         step();
      end
      snap_ready = 1'b1;
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b1010) begin
         errors++;
         $display("FAIL hold_ready_cyc got v=%b snap=%b exp v=1 snap=1010", snap_valid, snap);
      end
      step();
      checks++;
      if (snap_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_release got v=%b busy=%b exp 0/0", snap_valid, busy);
      end
      snap_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      int gap;
      do_reset();
      chans = 4'b0011;
      cont = 1'b1;
      snap_ready = 1'b1;
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b1100);
      pulse_start();
      wait_valid(4 * SCAN_LAT, n);
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b0011) begin
         errors++;
         $display("FAIL b2b_first got v=%b snap=%b exp v=1 snap=0011", snap_valid, snap);
      end
      chans = 4'b1100;
      step();
      gap = 1;
      while (!snap_valid && gap < 4 * SCAN_LAT) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy gap=%0d got busy=%b exp 1", gap, busy);
         end
         start = (gap == 2 || gap == 5) ? 1'b1 : 1'b0;
         step();
         gap++;
      end
      start = 1'b0;
      checks++;
      if (snap_valid !== 1'b1 || gap != SCAN_LAT) begin
         errors++;
         $display("FAIL b2b_spacing got v=%b gap=%0d exp v=1 gap=%0d", snap_valid, gap, SCAN_LAT);
      end
      cont = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || snap_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop got busy=%b v=%b exp 0/0", busy, snap_valid);
      end
      repeat (2 * SCAN_LAT) begin
         checks++;
         if (snap_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_queue got v=%b busy=%b exp 0/0", snap_valid, busy);
         end
         step();
      end
      snap_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      do_reset();
      chans = 4'b1010;
      snap_ready = 1'b1;
      pulse_start();
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({sel_out, snap, snap_valid, busy} !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid_vals got sel=%0d snap=%b v=%b busy=%b exp all 0",
                  sel_out, snap, snap_valid, busy);
      end
      chans = 4'b0110;
      exp_q.push_back(4'b0110);
      pulse_start();
      for (int c = 1; c <= SCAN_LAT - 1; c++) begin
         checks++;
         if (snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_early cyc=%0d got v=%b exp 0", c, snap_valid);
         end
         step();
      end
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b0110) begin
         errors++;
         $display("FAIL rst_mid_rescan got v=%b snap=%b exp v=1 snap=0110", snap_valid, snap);
      end
      step();
      snap_ready = 1'b0;
   endtask

`ifdef SCAN_CHANGE_DET_EN
   task automatic test_change_det();
      int n;
      do_reset();
      chans = 4'b0110;
      cont = 1'b1;
      snap_ready = 1'b1;
      exp_q.push_back(4'b0110);
      pulse_start();
      wait_valid(4 * SCAN_LAT, n);
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b0110) begin
         errors++;
         $display("FAIL det_first got v=%b snap=%b exp v=1 snap=0110", snap_valid, snap);
      end
      step();
      repeat (4 * SCAN_LAT) begin
         checks++;
         if (snap_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL det_suppress got v=%b busy=%b exp v=0 busy=1", snap_valid, busy);
         end
         step();
      end
      chans = 4'b0111;
      exp_q.push_back(4'b0111);
      wait_valid(2 * SCAN_LAT + 2, n);
      checks++;
      if (snap_valid !== 1'b1 || snap !== 4'b0111) begin
         errors++;
         $display("FAIL det_change got v=%b snap=%b exp v=1 snap=0111", snap_valid, snap);
      end
      cont = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL det_stop got busy=%b exp 0", busy);
      end
      snap_ready = 1'b0;
   endtask
`else
   task automatic test_repeat_emit();
      int n;
      do_reset();
      chans = 4'b0110;
      cont = 1'b1;
      snap_ready = 1'b1;
      exp_q.push_back(4'b0110);
      exp_q.push_back(4'b0110);
      pulse_start();
      wait_valid(4 * SCAN_LAT, n);
      step();
      wait_valid(4 * SCAN_LAT, n);
      checks++;
      if (snap_valid !== 1'b1 || n != SCAN_LAT - 1) begin
         errors++;
         $display("FAIL repeat_emit got v=%b wait=%0d exp v=1 wait=%0d", snap_valid, n, SCAN_LAT - 1);
      end
      cont = 1'b0;
      step();
      snap_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_rst_mid();
`ifdef SCAN_CHANGE_DET_EN
      test_change_det();
`else
      test_repeat_emit();
`endif
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
